// File: rtl/general_register_file.sv
// general_register_file
// ---------------------------------------------------------------------------
// Operand stage for the 16-bit ALU. Holds four general registers (R1-R4) and
// four scratch registers (S1-S4). Every enabled register applies the same
// FunSel operation on the rising edge. Two independent combinational muxes
// drive the ALU A and B operand buses.
//
// Ports
//   Clock    in   1       system clock, all state updates on rising edge
//   Reset    in   1       synchronous active-high, clears all eight registers
//   I        in   DATA_W  write data (ALU result, memory data or immediate)
//   FunSel   in   3       operation applied to every enabled register
//   RegSel   in   4       write enables, bit0=R1 .. bit3=R4
//   ScrSel   in   4       write enables, bit0=S1 .. bit3=S4
//   OutASel  in   3       A read select: 0..3 = R1..R4, 4..7 = S1..S4
//   OutBSel  in   3       B read select, same encoding as OutASel
//   OutA     out  DATA_W  ALU operand A
//   OutB     out  DATA_W  ALU operand B
// ---------------------------------------------------------------------------
module general_register_file #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] I,
  input  logic [2:0]        FunSel,
  input  logic [3:0]        RegSel,
  input  logic [3:0]        ScrSel,
  input  logic [2:0]        OutASel,
  input  logic [2:0]        OutBSel,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB
);

  localparam int L = DATA_W / 2;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FS_DEC         = 3'b000,
    FS_INC         = 3'b001,
    FS_LOAD        = 3'b010,
    FS_CLEAR       = 3'b011,
    FS_CLR_LOADLO  = 3'b100,
    FS_LOADLO      = 3'b101,
    FS_LOADHI      = 3'b110,
    FS_SEXT_LOADLO = 3'b111
  } fun_sel_e;

  // Unified enable vector: indices 0..3 are R1..R4, 4..7 are S1..S4, which
  // matches the read-select encoding so one index space serves both paths.
  logic [7:0]        w_en;
  logic [DATA_W-1:0] w_regs [8];

  assign w_en = {ScrSel, RegSel};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;
      logic [DATA_W-1:0] w_next;

      // Next value is computed from this register's own current value, so
      // INC/DEC on several registers at once stay independent.
      always_comb begin
        w_next = r_q;
        case (FunSel)
          FS_DEC:         w_next = r_q - ONE;
          FS_INC:         w_next = r_q + ONE;
          FS_LOAD:        w_next = I;
          FS_CLEAR:       w_next = '0;
          FS_CLR_LOADLO:  w_next = {{L{1'b0}}, I[L-1:0]};
          FS_LOADLO:      w_next = {r_q[DATA_W-1:L], I[L-1:0]};
          FS_LOADHI:      w_next = {I[L-1:0], r_q[L-1:0]};
          FS_SEXT_LOADLO: w_next = {{L{I[L-1]}}, I[L-1:0]};
          default:        w_next = r_q;
        endcase
      end

      // The enable gates the update, so an unknown FunSel on a disabled
      // register never reaches its state.
      always_ff @(posedge Clock) begin
        if (Reset) begin
          r_q <= '0;
        end else if (w_en[gi]) begin
          r_q <= w_next;
        end
      end

      assign w_regs[gi] = r_q;
    end
  endgenerate

  // Read muxes see register state only; a value on I becomes visible after
  // the edge that stores it, which keeps the ALU write-back path loop-free.
  assign OutA = w_regs[OutASel];
  assign OutB = w_regs[OutBSel];

endmodule

// File: tb/tb_general_register_file.sv
// tb_general_register_file
// Directed bench for general_register_file. Expected register contents are
// queued when an operation is driven and popped/compared once the edge that
// applies it has passed.
module tb_general_register_file;

  localparam int DATA_W = 16;

  localparam logic [2:0] F_DEC  = 3'b000;
  localparam logic [2:0] F_INC  = 3'b001;
  localparam logic [2:0] F_LOAD = 3'b010;
  localparam logic [2:0] F_CLR  = 3'b011;
  localparam logic [2:0] F_CLLO = 3'b100;
  localparam logic [2:0] F_LDLO = 3'b101;
  localparam logic [2:0] F_LDHI = 3'b110;
  localparam logic [2:0] F_SEXT = 3'b111;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [DATA_W-1:0] I;
  logic [2:0]        FunSel;
  logic [3:0]        RegSel;
  logic [3:0]        ScrSel;
  logic [2:0]        OutASel;
  logic [2:0]        OutBSel;
  logic [DATA_W-1:0] OutA;
  logic [DATA_W-1:0] OutB;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct {
    string       tag;
    logic [2:0]  sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  general_register_file #(.DATA_W(DATA_W)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .I       (I),
    .FunSel  (FunSel),
    .RegSel  (RegSel),
    .ScrSel  (ScrSel),
    .OutASel (OutASel),
    .OutBSel (OutBSel),
    .OutA    (OutA),
    .OutB    (OutB)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-24s got %h expected %h ok", tag, obs, exp);
    end else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_reg(input string tag, input logic [2:0] sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  // Enables are idle here, so reading across clock edges cannot disturb state.
  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      OutASel = e.sel;
      OutBSel = e.sel;
      #1;
      check({e.tag, "/A"}, OutA, e.exp);
      check({e.tag, "/B"}, OutB, e.exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    Reset  = 1'b0;
    RegSel = 4'b0000;
    ScrSel = 4'b0000;
  endtask

  task automatic op(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                    input logic [15:0] data);
    FunSel = fs;
    RegSel = rs;
    ScrSel = ss;
    I      = data;
    step();
  endtask

  initial begin
    Reset = 1'b1; I = '0; FunSel = F_LOAD; RegSel = '0; ScrSel = '0;
    OutASel = 3'd0; OutBSel = 3'd0;

    // Reset state
    step();
    for (int k = 0; k < 8; k++) expect_reg("por", 3'(k), 16'h0000);
    drain();

    // Load all eight with distinct non-zero values, then reset
    for (int k = 0; k < 4; k++) op(F_LOAD, 4'(1 << k), 4'b0000, 16'h1111 * 16'(k + 1));
    for (int k = 0; k < 4; k++) op(F_LOAD, 4'b0000, 4'(1 << k), 16'h1111 * 16'(k + 5));
    expect_reg("ld_r3", 3'd2, 16'h3333);
    expect_reg("ld_s2", 3'd5, 16'h6666);
    drain();
    Reset = 1'b1;
    step();
    for (int k = 0; k < 8; k++) expect_reg("rst_sweep", 3'(k), 16'h0000);
    drain();

    // LOAD on R1,R3 only; no write-through before the edge
    op(F_LOAD, 4'b0010, 4'b0000, 16'hBEEF);
    op(F_LOAD, 4'b1000, 4'b0000, 16'hCAFE);
    @(negedge Clock);
    OutASel = 3'd0; OutBSel = 3'd2;
    FunSel = F_LOAD; RegSel = 4'b0101; ScrSel = 4'b0000; I = 16'h1234;
    #1;
    check("pre_edge_A", OutA, 16'h0000);
    check("pre_edge_B", OutB, 16'h0000);
    step();
    check("post_edge_A_R1", OutA, 16'h1234);
    check("post_edge_B_R3", OutB, 16'h1234);
    expect_reg("r2_kept", 3'd1, 16'hBEEF);
    expect_reg("r4_kept", 3'd3, 16'hCAFE);
    drain();

    // INC/DEC wrap, and independent INC on two registers
    op(F_LOAD, 4'b0010, 4'b0000, 16'hFFFF);
    op(F_INC, 4'b0010, 4'b0000, 16'h0000);
    expect_reg("r2_inc_wrap", 3'd1, 16'h0000);
    drain();
    op(F_DEC, 4'b0010, 4'b0000, 16'h0000);
    expect_reg("r2_dec_wrap", 3'd1, 16'hFFFF);
    drain();
    op(F_DEC, 4'b0000, 4'b1000, 16'h0000);
    expect_reg("s4_dec_wrap", 3'd7, 16'hFFFF);
    expect_reg("s3_untouched", 3'd6, 16'h0000);
    drain();
    op(F_INC, 4'b0011, 4'b0000, 16'h0000);
    expect_reg("multi_inc_r1", 3'd0, 16'h1235);
    expect_reg("multi_inc_r2", 3'd1, 16'h0000);
    drain();

    // Byte operations on R4
    op(F_LOAD, 4'b1000, 4'b0000, 16'hABCD);
    op(F_LDLO, 4'b1000, 4'b0000, 16'h0012);
    expect_reg("loadlo", 3'd3, 16'hAB12);
    drain();
    op(F_LDHI, 4'b1000, 4'b0000, 16'h0077);
    expect_reg("loadhi", 3'd3, 16'h7712);
    drain();
    op(F_CLLO, 4'b1000, 4'b0000, 16'h9980);
    expect_reg("clr_loadlo", 3'd3, 16'h0080);
    drain();
    op(F_SEXT, 4'b1000, 4'b0000, 16'h0080);
    expect_reg("sext_neg", 3'd3, 16'hFF80);
    drain();
    op(F_SEXT, 4'b1000, 4'b0000, 16'h007F);
    expect_reg("sext_pos", 3'd3, 16'h007F);
    drain();

    // Disabled registers ignore FunSel, even unknown
    FunSel = 3'bxxx; RegSel = 4'b0000; ScrSel = 4'b0000; I = 16'hDEAD;
    step();
    expect_reg("hold_x_r4", 3'd3, 16'h007F);
    expect_reg("hold_x_s4", 3'd7, 16'hFFFF);
    drain();

    // Clear all eight
    op(F_LOAD, 4'b1111, 4'b1111, 16'h0F0F);
    expect_reg("all_load_s1", 3'd4, 16'h0F0F);
    drain();
    op(F_CLR, 4'b1111, 4'b1111, 16'hFFFF);
    for (int k = 0; k < 8; k++) expect_reg("all_clear", 3'(k), 16'h0000);
    drain();

    // Reset beats a simultaneous LOAD
    op(F_LOAD, 4'b1111, 4'b1111, 16'h0F0F);
    Reset = 1'b1;
    op(F_LOAD, 4'b1111, 4'b1111, 16'h5555);
    for (int k = 0; k < 8; k++) expect_reg("rst_prio", 3'(k), 16'h0000);
    drain();

    // ALU write-back loop: R1 increments through I each cycle
    op(F_LOAD, 4'b0001, 4'b0000, 16'h0003);
    OutASel = 3'd0; OutBSel = 3'd0;
    for (int k = 0; k < 5; k++) begin
      expect_reg("wb_loop", 3'd0, 16'(4 + k));
      I = OutA + 16'd1;
      FunSel = F_LOAD; RegSel = 4'b0001; ScrSel = 4'b0000;
      @(posedge Clock);
      #1;
      begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.tag, OutA, e.exp);
      end
    end
    RegSel = 4'b0000;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
